// File: rtl/mod3_serial_tx_if.sv
// Word-in / serial-out bundle for the mod-3 serial transmitter.
// Slave is the transmitter; master is whatever feeds words and consumes the line.
interface mod3_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             ready;
    logic             out;
    logic             out_valid;
    logic             last;
    logic [1:0]       rem;
    logic             done;

    modport slave (
        input  data_in, load,
        output ready, out, out_valid, last, rem, done
    );

    modport master (
        output data_in, load,
        input  ready, out, out_valid, last, rem, done
    );
endinterface

// File: rtl/mod3_serial_tx.sv
// MSB-first serialiser tracking word mod 3; MOD3_TX_CHECK_EN appends two check bits so the frame is divisible by 3.
// Latency: MSB on the line the cycle after acceptance; done/rem one cycle after the last frame bit.
// Backpressure: ready only in IDLE; load while busy is dropped, never queued.
module mod3_serial_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    mod3_serial_tx_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef MOD3_TX_CHECK_EN
    localparam logic [1:0] S_CHECK = 2'd2;
`else
    localparam logic [CW-1:0] PEN_IDX = CW'(WIDTH - 2);
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       r_q, r_d, r_nxt;
    logic             out_q, out_d;
    logic             vld_q, vld_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic [1:0]       rem_q, rem_d;

    // Same transition table as the receiver FSM: r' = (2r + b) mod 3.
    function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
        case (r)
            2'd0:    return b ? 2'd1 : 2'd0;
            2'd1:    return b ? 2'd0 : 2'd2;
            2'd2:    return b ? 2'd2 : 2'd1;
            default: return 2'd0;
        endcase
    endfunction

`ifdef MOD3_TX_CHECK_EN
    // Check bits c1,c0 such that 4r + {c1,c0} is 0 mod 3.
    function automatic logic [1:0] mod3_check(input logic [1:0] r);
        case (r)
            2'd1:    return 2'b10;
            2'd2:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction
`endif

    assign r_nxt = mod3_step(r_q, shreg_q[WIDTH-1]);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        out_d   = 1'b0;
        vld_d   = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    state_d = S_SHIFT;
                    shreg_d = bus.data_in;
                    cnt_d   = '0;
                    r_d     = 2'd0;
                    out_d   = bus.data_in[WIDTH-1];
                    vld_d   = 1'b1;
                end
            end
            S_SHIFT: begin
                r_d     = r_nxt;
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
`ifdef MOD3_TX_CHECK_EN
                    state_d = S_CHECK;
                    cnt_d   = '0;
                    shreg_d = '0;
                    shreg_d[WIDTH-1 -: 2] = mod3_check(r_nxt);
                    out_d   = shreg_d[WIDTH-1];
                    vld_d   = 1'b1;
`else
                    state_d = S_IDLE;
                    rem_d   = r_nxt;
                    done_d  = 1'b1;
`endif
                end else begin
                    out_d = shreg_q[WIDTH-2];
                    vld_d = 1'b1;
`ifndef MOD3_TX_CHECK_EN
                    last_d = (cnt_q == PEN_IDX);
`endif
                end
            end
`ifdef MOD3_TX_CHECK_EN
            S_CHECK: begin
                // r_q keeps the data-only remainder; check bits never fold into rem.
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == '0) begin
                    out_d  = shreg_q[WIDTH-2];
                    vld_d  = 1'b1;
                    last_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    rem_d   = r_q;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            r_q     <= 2'd0;
            out_q   <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.ready     = (state_q == S_IDLE);
    assign bus.out       = out_q;
    assign bus.out_valid = vld_q;
    assign bus.last      = last_q;
    assign bus.done      = done_q;
    assign bus.rem       = rem_q;
endmodule

// File: tb/tb_mod3_serial_tx.sv
// Directed bench for mod3_serial_tx (WIDTH=8); frame length and check bits follow MOD3_TX_CHECK_EN.
module tb_mod3_serial_tx;
`ifdef MOD3_TX_CHECK_EN
    localparam int F = 10;
`else
    localparam int F = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    mod3_serial_tx_if #(.WIDTH(8)) bus ();
    mod3_serial_tx #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one whole frame from its first bit cycle through the done cycle.
    task automatic run_frame(input logic [7:0] word, input logic [1:0] cbits,
                             input logic [1:0] rem_exp, input bit do_start,
                             input bit glitch, input string tag);
        logic [9:0] fb;
        logic       b;
        int         rx;
        fb = {word, cbits};
        rx = 0;
        if (do_start) begin
            chk({tag, ".ready_pre"}, bus.ready, 1'b1);
            bus.load    = 1'b1;
            bus.data_in = word;
            tick();
            bus.load    = 1'b0;
            bus.data_in = ~word;
        end
        for (int i = 0; i < F; i++) begin
            b = fb[9-i];
            chk($sformatf("%s.vld%0d", tag, i), bus.out_valid, 1'b1);
            chk($sformatf("%s.bit%0d", tag, i), bus.out, b);
            chk($sformatf("%s.last%0d", tag, i), bus.last, (i == F-1));
            rx = (2*rx + int'(b)) % 3;
            if (glitch && i == 4) begin
                bus.load    = 1'b1;
                bus.data_in = 8'hFF;
            end
            if (glitch && i == 5) bus.load = 1'b0;
            if (glitch && i == F-1) begin
                bus.load    = 1'b1;
                bus.data_in = 8'h03;
            end
            tick();
        end
        chk({tag, ".done"}, bus.done, 1'b1);
        chk({tag, ".vld_end"}, bus.out_valid, 1'b0);
        chk({tag, ".last_end"}, bus.last, 1'b0);
        chk({tag, ".rem"}, bus.rem, rem_exp);
        chk({tag, ".ready_end"}, bus.ready, 1'b1);
`ifdef MOD3_TX_CHECK_EN
        chk({tag, ".rx_divisible"}, rx, 0);
`else
        chk({tag, ".rx_rem"}, rx, rem_exp);
`endif
    endtask

    initial begin
        bus.load    = 1'b0;
        bus.data_in = 8'h00;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out", bus.out, 1'b0);
        chk("rst.vld", bus.out_valid, 1'b0);
        chk("rst.last", bus.last, 1'b0);
        chk("rst.done", bus.done, 1'b0);
        chk("rst.rem", bus.rem, 2'd0);
        chk("rst.ready", bus.ready, 1'b1);
        rst = 1'b1;
        tick();
        chk("idle.vld", bus.out_valid, 1'b0);
        chk("idle.out", bus.out, 1'b0);
        chk("idle.ready", bus.ready, 1'b1);

        // Back-to-back frames, each accepted on the previous done cycle.
        run_frame(8'h06, 2'b00, 2'd0, 1'b1, 1'b0, "w06");
        run_frame(8'h07, 2'b10, 2'd1, 1'b1, 1'b0, "w07");
        run_frame(8'h05, 2'b01, 2'd2, 1'b1, 1'b0, "w05");
        tick();
        chk("gap.done", bus.done, 1'b0);
        chk("gap.rem_hold", bus.rem, 2'd2);

        // Abort 8'h0B at bit 5 with an asynchronous reset.
        bus.load    = 1'b1;
        bus.data_in = 8'h0B;
        tick();
        bus.load = 1'b0;
        repeat (5) tick();
        chk("abort.vld_pre", bus.out_valid, 1'b1);
        chk("abort.ready_pre", bus.ready, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("abort.vld", bus.out_valid, 1'b0);
        chk("abort.last", bus.last, 1'b0);
        chk("abort.out", bus.out, 1'b0);
        chk("abort.rem", bus.rem, 2'd0);
        chk("abort.ready", bus.ready, 1'b1);
        tick();
        chk("abort.done_rst", bus.done, 1'b0);
        rst = 1'b1;
        tick();
        chk("abort.done_post", bus.done, 1'b0);
        chk("abort.vld_post", bus.out_valid, 1'b0);

        // 8'hFF request mid-frame is dropped; 8'h03 held and taken on the done cycle.
        run_frame(8'hA5, 2'b00, 2'd0, 1'b1, 1'b1, "wA5");
        tick();
        bus.load    = 1'b0;
        bus.data_in = 8'hFC;
        chk("w03.done_clr", bus.done, 1'b0);
        chk("w03.ready_busy", bus.ready, 1'b0);
        run_frame(8'h03, 2'b00, 2'd0, 1'b0, 1'b0, "w03");

        // Transmission after the aborted frame.
        run_frame(8'h0B, 2'b01, 2'd2, 1'b1, 1'b0, "w0B");
        tick();
        chk("final.done", bus.done, 1'b0);
        chk("final.rem", bus.rem, 2'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
